// File: rtl/mips_pkg.sv
// Shared loader types: FSM state encoding and instruction-word constants.
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int BYTE_WIDTH_DEF = 8;
  localparam int BYTES_PER_WORD = DATA_WIDTH_DEF / BYTE_WIDTH_DEF;
  localparam logic [DATA_WIDTH_DEF-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// word_assembler: big-endian byte shift register with a one-cycle
// word_valid pulse when the last byte of a word has been shifted in.
import mips_pkg::*;

module word_assembler #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BYTE_WIDTH = BYTE_WIDTH_DEF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_enable,
  input  logic                  i_rx_done,
  input  logic [BYTE_WIDTH-1:0] i_rx_data,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_word_valid
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_WIDTH-BYTE_WIDTH-1:0] r_shift;
  logic [IW-1:0]                    r_idx;
  logic [DATA_WIDTH-1:0]            w_next;

  assign w_next = {r_shift, i_rx_data};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shift      <= '0;
      r_idx        <= '0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
    end else begin
      o_word_valid <= 1'b0;
      if (i_clear) begin
        r_shift <= '0;
        r_idx   <= '0;
      end else if (i_enable && i_rx_done) begin
        if (r_idx == IW'(NB-1)) begin
          // Word complete: publish it and start the next one at once
          o_word       <= w_next;
          o_word_valid <= 1'b1;
          r_shift      <= '0;
          r_idx        <= '0;
        end else begin
          r_shift <= w_next[DATA_WIDTH-BYTE_WIDTH-1:0];
          r_idx   <= r_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Serial-byte to instruction-memory loader; stalls the pipeline while loading.
// Optional inter-byte timeout: define INSTR_LOADER_TIMEOUT_EN.
import mips_pkg::*;

module instr_loader #(
  parameter int                    DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int                    BYTE_WIDTH     = BYTE_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD      = HALT_WORD_DEF,
  parameter int                    ADDR_STEP      = 4,
  parameter int                    MAX_WORDS      = 256,
  parameter int                    TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_load_req,
  input  logic                  i_rx_done,
  input  logic [BYTE_WIDTH-1:0] i_rx_data,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [DATA_WIDTH-1:0] o_address,
  output logic                  o_loading,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [DATA_WIDTH-1:0] o_word_count
);

  loader_state_t         r_state;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_word_valid;
  logic                  w_start;
  logic                  w_enable;
  logic                  w_tmo_hit;

  assign w_start  = i_load_req &&
                    (r_state == IDLE || r_state == DONE ||
                     r_state == ERROR);
  assign w_enable = (r_state == RECV) || (r_state == WRITE);

  word_assembler #(
    .DATA_WIDTH(DATA_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH)
  ) u_asm (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_clear     (w_start),
    .i_enable    (w_enable),
    .i_rx_done   (i_rx_done),
    .i_rx_data   (i_rx_data),
    .o_word      (w_word),
    .o_word_valid(w_word_valid)
  );

`ifdef INSTR_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo;

  assign w_tmo_hit = (r_state == RECV) && !i_rx_done &&
                     (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset || r_state != RECV || i_rx_done) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 1'b1;
    end
  end
`else
  // Timeout never fires in this build
  assign w_tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      o_instruccion <= '0;
      o_address     <= '0;
      o_loading     <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_word_count  <= '0;
    end else begin
      o_loading <= 1'b0;
      if (w_start) begin
        r_state      <= RECV;
        r_addr       <= '0;
        o_word_count <= '0;
        o_busy       <= 1'b1;
        o_done       <= 1'b0;
        o_error      <= 1'b0;
      end else begin
        unique case (r_state)
          RECV: begin
            if (w_word_valid) begin
              r_state       <= WRITE;
              o_loading     <= 1'b1;
              o_instruccion <= w_word;
              o_address     <= r_addr;
            end else if (w_tmo_hit) begin
              r_state <= ERROR;
              o_busy  <= 1'b0;
              o_error <= 1'b1;
            end
          end
          WRITE: begin
            r_addr       <= r_addr + DATA_WIDTH'(ADDR_STEP);
            o_word_count <= o_word_count + 1'b1;
            if (o_instruccion == HALT_WORD) begin
              r_state <= DONE;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end else if (o_word_count ==
                         DATA_WIDTH'(MAX_WORDS - 1)) begin
              r_state <= ERROR;
              o_busy  <= 1'b0;
              o_error <= 1'b1;
            end else begin
              r_state <= RECV;
            end
          end
          IDLE, DONE, ERROR: r_state <= r_state;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader (MAX_WORDS=4, TIMEOUT_CYCLES=100).
module tb_instr_loader;

  localparam int          MAXW = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, load, rxd;
  logic [7:0]  rxdata;
  logic [31:0] o_instruccion, o_address, o_word_count;
  logic        o_loading, o_busy, o_done, o_error;

  always #5 clk = ~clk;

  instr_loader #(
    .MAX_WORDS     (MAXW),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_load_req   (load),
    .i_rx_done    (rxd),
    .i_rx_data    (rxdata),
    .o_instruccion(o_instruccion),
    .o_address    (o_address),
    .o_loading    (o_loading),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_word_count (o_word_count)
  );

  typedef struct {
    logic [31:0] d;
    logic [31:0] a;
  } wr_t;

  typedef logic [31:0] wq_t[$];

  typedef struct {
    int          n;
    logic [31:0] w[5];
    int          gap;
    logic        exp_done;
    logic        exp_err;
    int          exp_cnt;
  } vec_t;

  int  checks = 0;
  int  errors = 0;
  wr_t obs[$];

  always @(negedge clk)
    if (o_loading) obs.push_back('{d: o_instruccion, a: o_address});

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rxd    = 1'b1;
    rxdata = b;
    tick();
    rxd = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) send_byte(t[31-8*i -: 8], gap);
  endtask

  task automatic pulse_load;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Reference: words are written in order at 4-byte steps until the
  // HALT word (written too) or until memory holds MAXW words.
  task automatic run_and_check(input wq_t words, input int gap,
                               input string tag);
    wr_t exp[$];
    bit  edone, eerr;
    int  nchk;
    edone = 0;
    eerr  = 0;
    for (int i = 0; i < words.size(); i++) begin
      exp.push_back('{d: words[i], a: 32'(i * 4)});
      if (words[i] == HALT) begin
        edone = 1;
        break;
      end
      if (i + 1 == MAXW) begin
        eerr = 1;
        break;
      end
    end
    obs.delete();
    pulse_load();
    chk({tag, " busy_after_req"}, 32'(o_busy), 32'd1);
    foreach (words[i]) send_word(words[i], gap);
    repeat (6) tick();
    chk({tag, " nwrites"}, 32'(obs.size()), 32'(exp.size()));
    nchk = (obs.size() < exp.size()) ? obs.size() : exp.size();
    for (int i = 0; i < nchk; i++) begin
      chk($sformatf("%s wdata%0d", tag, i), obs[i].d, exp[i].d);
      chk($sformatf("%s waddr%0d", tag, i), obs[i].a, exp[i].a);
    end
    chk({tag, " count"}, o_word_count, 32'(exp.size()));
    chk({tag, " done"}, 32'(o_done), 32'(edone));
    chk({tag, " error"}, 32'(o_error), 32'(eerr));
    chk({tag, " busy"}, 32'(o_busy), 32'(!(edone || eerr)));
    chk({tag, " loading"}, 32'(o_loading), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " instr"}, o_instruccion, 32'd0);
    chk({tag, " addr"}, o_address, 32'd0);
    chk({tag, " count"}, o_word_count, 32'd0);
    chk({tag, " flags"},
        32'({o_loading, o_busy, o_done, o_error}), 32'd0);
  endtask

  vec_t vt[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    wq_t q;
    vt[0] = '{2, '{32'h2008_0005, HALT, 0, 0, 0}, 1, 1'b1, 1'b0, 2};
    vt[1] = '{4, '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                   HALT, 0}, 0, 1'b1, 1'b0, 4};
    vt[2] = '{5, '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
                   32'hA000_0004, 32'hA000_0005}, 0, 1'b0, 1'b1, 4};
    vt[3] = '{1, '{HALT, 0, 0, 0, 0}, 2, 1'b1, 1'b0, 1};
    vt[4] = '{3, '{32'h0102_0304, 32'hFFFF_FFFE, HALT, 0, 0},
              1, 1'b1, 1'b0, 3};

    rst    = 1'b1;
    load   = 1'b0;
    rxd    = 1'b0;
    rxdata = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_all_zero("reset");

    // Rx bytes while IDLE must be ignored
    send_word(32'hDEAD_BEEF, 0);
    chk("idle_ignore loading", 32'(o_loading), 32'd0);

    for (int v = 0; v < 5; v++) begin
      q.delete();
      for (int k = 0; k < vt[v].n; k++) q.push_back(vt[v].w[k]);
      run_and_check(q, vt[v].gap, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d tbl_count", v), o_word_count,
          32'(vt[v].exp_cnt));
      chk($sformatf("vec%0d tbl_flags", v), 32'({o_done, o_error}),
          32'({vt[v].exp_done, vt[v].exp_err}));
    end

    // Latency: write strobe two cycles after the 4th byte's rx_done
    obs.delete();
    pulse_load();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    rxd    = 1'b1;
    rxdata = 8'h78;
    tick();
    rxd = 1'b0;
    chk("lat cyc1 loading", 32'(o_loading), 32'd0);
    tick();
    chk("lat cyc2 loading", 32'(o_loading), 32'd1);
    chk("lat instr", o_instruccion, 32'h1234_5678);
    chk("lat addr", o_address, 32'd0);
    tick();
    chk("lat one_cycle", 32'(o_loading), 32'd0);
    chk("lat count", o_word_count, 32'd1);
    send_word(HALT, 0);
    repeat (4) tick();
    chk("lat done", 32'(o_done), 32'd1);

    // Reset in the middle of a word
    pulse_load();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("midreset");
    q = '{32'hCAFE_BABE, HALT};
    run_and_check(q, 1, "after_reset");

    for (int it = 0; it < 40; it++) begin
      int n;
      q.delete();
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++)
        q.push_back(($urandom_range(0, 3) == 0) ? HALT : $urandom);
      if (n < MAXW) q[n-1] = HALT;
      run_and_check(q, $urandom_range(0, 2), $sformatf("rnd%0d", it));
    end

`ifdef INSTR_LOADER_TIMEOUT_EN
    begin
      int k;
      obs.delete();
      pulse_load();
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h03, 0);
      k = 0;
      while (!o_error && k < 300) begin
        tick();
        k++;
      end
      chk("tmo cycles", 32'(k), 32'd100);
      chk("tmo writes", 32'(obs.size()), 32'd0);
      chk("tmo busy", 32'(o_busy), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
